// File: rtl/alu_operand_fifo.sv
// Operand-pair FIFO between decode and the ALU, plus an acknowledged result register.
// Head entry is presented first-word-fall-through; no bypass from input to output when empty.
module alu_operand_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             err_overflow,
  input  logic [WIDTH-1:0] res_in,
  input  logic             res_en,
  output logic [WIDTH-1:0] res_out,
  output logic             res_valid,
  input  logic             res_ack
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  pair_t           mem [DEPTH];
  pair_t           head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;

  // Stale array contents must never leak out, so the head is masked while empty.
  assign head  = mem[rd_ptr];
  assign out_a = empty ? '0 : head.a;
  assign out_b = empty ? '0 : head.b;

  // NOTE: the storage array has no reset; only pointers/count define validity,
  // which keeps the array as plain flops/RAM without a reset network.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr].a <= in_a;
      mem[wr_ptr].b <= in_b;
    end
  end

  // NOTE: always_comb assigns a default first so every path drives count_d and no latch forms.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_d;
    end
  end

  // Sticky until flush or reset; an offer while full is the only set condition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_overflow <= 1'b0;
    end else if (flush) begin
      err_overflow <= 1'b0;
    end else if (in_valid && full) begin
      err_overflow <= 1'b1;
    end
  end

  // A new capture takes priority over an acknowledge in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_out   <= '0;
      res_valid <= 1'b0;
    end else if (res_en) begin
      res_out   <= res_in;
      res_valid <= 1'b1;
    end else if (res_ack) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_fifo.sv
// Scoreboard bench for alu_operand_fifo: accepted pairs are queued by a bench-side
// model and compared against the head whenever the model predicts a pop.
module tb_alu_operand_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [WIDTH-1:0] in_a, in_b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_a, out_b;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             err_overflow;
  logic [WIDTH-1:0] res_in;
  logic             res_en;
  logic [WIDTH-1:0] res_out;
  logic             res_valid;
  logic             res_ack;

  logic [2*WIDTH-1:0] sb_q[$];
  bit                 m_err;
  int                 n_checks = 0;
  int                 n_fail   = 0;

  alu_operand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
    .out_a(out_a), .out_b(out_b), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .err_overflow(err_overflow),
    .res_in(res_in), .res_en(res_en), .res_out(res_out),
    .res_valid(res_valid), .res_ack(res_ack)
  );

  always #5 clk = ~clk;

  // One clock: drive at negedge, compare popped data before the edge, update model, return at next negedge.
  task automatic cycle(input logic iv, input logic [7:0] a, input logic [7:0] b,
                       input logic ordy, input logic fl);
    bit m_push, m_pop, m_ovf;
    logic [2*WIDTH-1:0] exp;
    in_valid = iv; in_a = a; in_b = b; out_ready = ordy; flush = fl;
    #1;
    m_push = iv && (sb_q.size() < DEPTH);
    m_pop  = ordy && (sb_q.size() > 0);
    m_ovf  = iv && (sb_q.size() == DEPTH);
    if (m_pop && !fl) begin
      exp = sb_q[0];
      n_checks++;
      if ({out_a, out_b} !== exp) begin
        n_fail++;
        $display("FAIL pop_data: got a=%h b=%h expected a=%h b=%h", out_a, out_b, exp[15:8], exp[7:0]);
      end
    end
    @(posedge clk);
    if (fl) begin
      sb_q.delete();
      m_err = 1'b0;
    end else begin
      if (m_pop)  void'(sb_q.pop_front());
      if (m_push) sb_q.push_back({a, b});
      if (m_ovf)  m_err = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (count !== 3'd0)      begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if ({out_a, out_b} !== 16'h0) begin n_fail++; $display("FAIL reset_out_data: got %h%h expected 0000", out_a, out_b); end
    n_checks++; if (res_valid !== 1'b0 || res_out !== 8'h00) begin n_fail++; $display("FAIL reset_result: got v=%b d=%h expected v=0 d=00", res_valid, res_out); end
    n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_overflow); end
  endtask

  task automatic test_single_push;
    cycle(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b expected 1", out_valid); end
    n_checks++; if (count !== 3'd1)     begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
    n_checks++; if (out_a !== 8'h12 || out_b !== 8'h34) begin n_fail++; $display("FAIL single_head: got %h/%h expected 12/34", out_a, out_b); end
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL single_drain: got v=%b c=%0d expected v=0 c=0", out_valid, count); end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 8'(8'h80 + i), 1'b0, 1'b0);
    n_checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_state: got c=%0d rdy=%b expected c=4 rdy=0", count, in_ready); end
    n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL full_err_early: got %b expected 0", err_overflow); end
    cycle(1'b1, 8'h05, 8'h85, 1'b0, 1'b0);
    n_checks++; if (err_overflow !== m_err || count !== 3'd4) begin n_fail++; $display("FAIL overflow: got err=%b c=%0d expected err=%b c=4", err_overflow, count, m_err); end
    // Empty-side pops with out_ready held high beyond the last entry must be ignored.
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL overflow_drain: got c=%0d v=%b expected c=0 v=0", count, out_valid); end
    n_checks++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err_overflow); end
  endtask

  task automatic test_flush;
    cycle(1'b1, 8'h21, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h23, 8'h24, 1'b0, 1'b0);
    n_checks++; if (count !== 3'd2 || err_overflow !== 1'b1) begin n_fail++; $display("FAIL preflush: got c=%0d err=%b expected c=2 err=1", count, err_overflow); end
    cycle(1'b1, 8'h77, 8'h77, 1'b1, 1'b1);
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_state: got c=%0d v=%b expected c=0 v=0", count, out_valid); end
    n_checks++; if (err_overflow !== m_err) begin n_fail++; $display("FAIL flush_err: got %b expected %b", err_overflow, m_err); end
    n_checks++; if ({out_a, out_b} !== 16'h0) begin n_fail++; $display("FAIL flush_data: got %h%h expected 0000", out_a, out_b); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hA0 + i), 8'(8'hB0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 8'(8'h10 + i), 8'(8'h40 + i), 1'b1, 1'b0);
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 3", i, count); end
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    n_checks++; if (sb_q.size() != 0 || count !== 3'd0) begin n_fail++; $display("FAIL b2b_drain: got c=%0d expected 0", count); end
  endtask

  task automatic test_result;
    res_en = 1'b1; res_in = 8'hA5;
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    res_en = 1'b0;
    n_checks++; if (res_out !== 8'hA5 || res_valid !== 1'b1) begin n_fail++; $display("FAIL res_capture: got d=%h v=%b expected d=a5 v=1", res_out, res_valid); end
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL res_hold: got v=%b expected 1", res_valid); end
    res_ack = 1'b1;
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    res_ack = 1'b0;
    n_checks++; if (res_out !== 8'hA5 || res_valid !== 1'b0) begin n_fail++; $display("FAIL res_ack: got d=%h v=%b expected d=a5 v=0", res_out, res_valid); end
    res_en = 1'b1; res_ack = 1'b1; res_in = 8'h5A;
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    res_en = 1'b0; res_ack = 1'b0;
    n_checks++; if (res_out !== 8'h5A || res_valid !== 1'b1) begin n_fail++; $display("FAIL res_en_wins: got d=%h v=%b expected d=5a v=1", res_out, res_valid); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hC0 + i), 8'(8'hD0 + i), 1'b0, 1'b0);
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL prereset_count: got %0d expected 3", count); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset: got c=%0d v=%b expected c=0 v=0", count, out_valid); end
    n_checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_misc: got rv=%b rdy=%b expected rv=0 rdy=1", res_valid, in_ready); end
    sb_q.delete();
    m_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL post_reset: got v=%b c=%0d expected v=0 c=0", out_valid, count); end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b0; res_in = '0; res_en = 1'b0; res_ack = 1'b0;
    m_err = 1'b0;
    test_reset;
    test_single_push;
    test_overflow;
    test_flush;
    test_back_to_back;
    test_result;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
